fifo144_rd_unpack: RTL and testbench
====================================

Name: fifo144_rd_unpack

Overview:
Read-side controller for the 32x144 single-clock FIFO. It drains the FIFO by driving its rdreq, and absorbs the FIFO's fixed read latency in a small credit-managed holding buffer. Each 144-bit entry is presented as two 72-bit beats on a valid/ready stream toward downstream link-engine logic. It guarantees the FIFO never underflows and that downstream backpressure never loses data.

Parameters:
RD_LAT, 2, cycles from fifo_rdreq high to fifo_q valid (1 or 2 only; 2 matches FIFO built with PIPE=1).
BUF_DEPTH, 4, holding-buffer entries of 144 bits (power of 2, >= 2).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
fifo_q  input  144  FIFO read data, valid RD_LAT cycles after fifo_rdreq
fifo_usedw  input  6  FIFO fill level (0..32); reflects a pop one cycle after the rdreq
fifo_rdreq  output  1  FIFO pop strobe
out_data  output  72  beat data
out_valid  output  1  beat valid
out_ready  input  1  downstream accept
out_hi  output  1  0 = beat is fifo_q[71:0]; 1 = beat is fifo_q[143:72]
busy  output  1  reads in flight or buffer non-empty

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: fifo_rdreq=0 (combinationally gated by rst), out_valid=0, out_hi=0, busy=0, out_data=0. The in-flight shift register, inflight_cnt, buf_cnt, wptr, rptr and half are all cleared.
- Reset mid-operation: data returning from reads issued before reset is discarded, and no beat appears after reset.
- Counters: inflight_cnt and buf_cnt are $clog2(BUF_DEPTH)+1 bits wide. Invariant: inflight_cnt + buf_cnt <= BUF_DEPTH.
- Issue rule: fifo_rdreq = !rst && (fifo_usedw > {5'b0, rdreq_q}) && (inflight_cnt + buf_cnt < BUF_DEPTH).
  - rdreq_q is fifo_rdreq delayed one cycle. It compensates for the one-cycle usedw lag.
  - A pulse may be issued every cycle while usedw >= 2.
- Return tracking: an RD_LAT-deep shift register carries fifo_rdreq. Its output, ret, captures fifo_q into buf[wptr]; wptr increments and wraps mod BUF_DEPTH.
  - inflight_cnt increments on rdreq and decrements on ret. Both in the same cycle leaves it unchanged.
- Output:
  - out_valid = (buf_cnt != 0).
  - out_data = half ? buf[rptr][143:72] : buf[rptr][71:0].
  - out_hi = half.
- Handshake: a beat transfers on out_valid && out_ready.
  - half=0 -> half becomes 1.
  - half=1 -> half becomes 0, rptr increments (wraps), buf_cnt decrements.
  - While out_valid && !out_ready, out_data and out_hi are held stable.
  - out_valid never drops without a transfer.
- Buffer count: capture and final-beat pop in the same cycle leave buf_cnt unchanged. A capture with buf_cnt already at BUF_DEPTH is impossible by the credit rule; assert in simulation.
- busy = (inflight_cnt != 0) || (buf_cnt != 0).
- Throughput: with out_ready=1 the sustained rate is 72 bits/cycle (one entry per 2 cycles).
- Latency: first beat appears RD_LAT+1 cycles after the first rdreq.
- Empty FIFO: fifo_usedw=0 means no rdreq. The underflow output of the FIFO must never assert.

Optional Feature:
Macro FIFO144_RD_UNPACK_STATS_EN.
- Defined: adds two ports.
  - rd_cnt output 32: counts fifo_rdreq pulses.
  - stall_cnt output 32: counts cycles with out_valid && !out_ready.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
  - stats_clr input 1: synchronous clear of both counters; it wins over an increment in the same cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Hold rst=1 for 3 cycles with fifo_usedw=5 -> fifo_rdreq=0, out_valid=0, busy=0 throughout.
2. Single entry: fifo_usedw=1, model FIFO returns q=144'h1234_..._ABCD (RD_LAT=2), out_ready=1.
   - Exactly one rdreq pulse; usedw stays 1 in the lag cycle and no second pulse is issued.
   - Beat 1: out_hi=0, out_data=q[71:0]. Beat 2: out_hi=1, out_data=q[143:72]. Then out_valid=0, busy=0.
3. Backpressure: usedw=20, out_ready=0.
   - Exactly 4 rdreq pulses, then none; out_data stays q0[71:0] with out_hi=0 for 50 cycles.
   - Raise out_ready -> 40 beats in order, no drops or duplicates.
4. Streaming: model FIFO preloaded with 32 incrementing entries, out_ready=1.
   - 64 beats, out_valid continuous after the first beat, FIFO underflow never asserts, busy=0 at the end.
5. Random out_ready (50%) with random FIFO writes over 1000 entries -> scoreboard matches all beats; the invariant inflight_cnt+buf_cnt <= 4 holds every cycle.
6. Assert rst for 1 cycle with 2 reads in flight and 1 buffered entry -> no beats after reset; with FIFO144_RD_UNPACK_STATS_EN defined, rd_cnt=0 after reset and stall_cnt counts exactly 50 in scenario 3.

Source files
------------

// File: rtl/fifo144_rd_unpack.sv
// fifo144_rd_unpack: drains the 32x144 FIFO through a credit-managed holding buffer
// and presents each entry as two 72-bit beats. Define FIFO144_RD_UNPACK_STATS_EN for stats counters.
module fifo144_rd_unpack #(
    parameter int RD_LAT    = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [143:0] fifo_q,
    input  logic [5:0]   fifo_usedw,
    output logic         fifo_rdreq,
    output logic [71:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_hi,
`ifdef FIFO144_RD_UNPACK_STATS_EN
    output logic         busy,
    input  logic         stats_clr,
    output logic [31:0]  rd_cnt,
    output logic [31:0]  stall_cnt
`else
    output logic         busy
`endif
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    logic [RD_LAT-1:0] ret_sr;
    logic              ret;
    logic              rdreq_q;
    logic [CW-1:0]     inflight_cnt;
    logic [CW-1:0]     buf_cnt;
    logic [CW:0]       credit_used;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              half;
    logic              xfer;
    logic              pop;
    logic [143:0]      buf_mem [BUF_DEPTH];

    // usedw lags a pop by one cycle, so last cycle's rdreq is discounted before issuing again.
    assign credit_used = {1'b0, inflight_cnt} + {1'b0, buf_cnt};
    assign fifo_rdreq  = !rst && (fifo_usedw > {5'b0, rdreq_q})
                              && (credit_used < (CW+1)'(BUF_DEPTH));

    assign ret       = ret_sr[RD_LAT-1];
    assign out_valid = !rst && (buf_cnt != '0);
    assign out_hi    = !rst && half;
    assign out_data  = rst  ? '0 : (half ? buf_mem[rptr][143:72] : buf_mem[rptr][71:0]);
    assign busy      = !rst && ((inflight_cnt != '0) || (buf_cnt != '0));
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && half;

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) ret_sr <= '0;
                else     ret_sr <= fifo_rdreq;
            end
        end else begin : g_latn
            always_ff @(posedge clk) begin
                if (rst) ret_sr <= '0;
                else     ret_sr <= {ret_sr[RD_LAT-2:0], fifo_rdreq};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rdreq_q      <= 1'b0;
            inflight_cnt <= '0;
            buf_cnt      <= '0;
            wptr         <= '0;
            rptr         <= '0;
            half         <= 1'b0;
        end else begin
            rdreq_q <= fifo_rdreq;

            case ({fifo_rdreq, ret})
                2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase

            // An entry keeps its credit until its upper beat has been accepted.
            case ({ret, pop})
                2'b10:   buf_cnt <= buf_cnt + CW'(1);
                2'b01:   buf_cnt <= buf_cnt - CW'(1);
                default: buf_cnt <= buf_cnt;
            endcase

            if (ret)  wptr <= wptr + AW'(1);
            if (xfer) half <= !half;
            if (pop)  rptr <= rptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ret) buf_mem[wptr] <= fifo_q;
    end

    always_ff @(posedge clk) begin
        if (!rst && ret) assert (buf_cnt != DEPTH_C);
    end

`ifdef FIFO144_RD_UNPACK_STATS_EN
    // Both counters saturate; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            rd_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (fifo_rdreq && (rd_cnt != '1))
                rd_cnt <= rd_cnt + 32'd1;
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo144_rd_unpack.sv
// Testbench for fifo144_rd_unpack: FIFO model with lagging usedw, scoreboard of expected beats,
// table-driven single-entry vectors and multi-cycle scenarios (reset, backpressure, streaming, random).
module tb_fifo144_rd_unpack;

    localparam int RD_LAT    = 2;
    localparam int BUF_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [143:0] fifo_q;
    logic [5:0]   fifo_usedw;
    logic         fifo_rdreq;
    logic [71:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_hi;
    logic         busy;
`ifdef FIFO144_RD_UNPACK_STATS_EN
    logic         stats_clr;
    logic [31:0]  rd_cnt;
    logic [31:0]  stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo144_rd_unpack #(.RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .fifo_q(fifo_q),
        .fifo_usedw(fifo_usedw),
        .fifo_rdreq(fifo_rdreq),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_hi(out_hi),
        .busy(busy)
`ifdef FIFO144_RD_UNPACK_STATS_EN
        , .stats_clr(stats_clr),
        .rd_cnt(rd_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    typedef struct { logic hi; logic [71:0] data; } beat_t;
    typedef struct { logic hi; logic [71:0] data; int cyc; } log_t;
    typedef struct { logic [143:0] q; logic [71:0] exp_lo; logic [71:0] exp_hi; } vec_t;

    logic [143:0] mem[$];
    beat_t        exp_q[$];
    log_t         beat_log[$];
    logic [143:0] q_pipe [RD_LAT];
    vec_t         vecs [4];

    int n_checks, n_fail;
    int cycle, rdreq_total, beats, stall_seen, underflow, outstanding;
    int last_rdreq_cyc, wr_remaining, wr_idx;
    logic rst_next, ready_next, random_ready, clr_next;
    logic stall_prev, prev_hi;
    logic [71:0] prev_data;

    function automatic logic [143:0] junk();
        return {16'hDEAD, 32'($urandom()), 32'($urandom()), 32'($urandom()), 32'($urandom())};
    endfunction

    function automatic logic [143:0] mk_entry(input int n);
        logic [31:0] v;
        v = n;
        return {16'hBEEF, v, ~v, 32'h5A5A_5A5A, v ^ 32'h0F0F_0F0F};
    endfunction

    task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample/check at negedge, then advance the FIFO model and drive inputs after posedge.
    task automatic applyStimulus();
        logic [143:0] popped;
        logic         did_pop;
        int           size_before;
        beat_t        e;
        @(negedge clk);
        cycle++;
        did_pop     = 1'b0;
        popped      = '0;
        size_before = mem.size();
        if (rst) begin
            checkOutput("rst_rdreq", fifo_rdreq, 0);
            checkOutput("rst_valid", out_valid, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_hi", out_hi, 0);
            checkOutput("rst_data", out_data, 0);
            exp_q.delete();
            outstanding = 0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, prev_data);
                checkOutput("hold_hi", out_hi, prev_hi);
            end
            if (out_valid && out_ready) begin
                beats++;
                beat_log.push_back('{out_hi, out_data, cycle});
                checkOutput("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("beat_hi", out_hi, e.hi);
                    checkOutput("beat_data", out_data, e.data);
                end
                if (out_hi) outstanding--;
            end
            if (out_valid && !out_ready) stall_seen++;
            if (fifo_rdreq) begin
                rdreq_total++;
                last_rdreq_cyc = cycle;
                outstanding++;
                if (mem.size() == 0) begin
                    underflow++;
                end else begin
                    popped  = mem.pop_front();
                    did_pop = 1'b1;
                    exp_q.push_back('{1'b0, popped[71:0]});
                    exp_q.push_back('{1'b1, popped[143:72]});
                end
            end
            checkOutput("credit_invariant", outstanding <= BUF_DEPTH, 1);
        end
        stall_prev = !rst && out_valid && !out_ready;
        prev_data  = out_data;
        prev_hi    = out_hi;
        @(posedge clk);
        #1;
        fifo_usedw = 6'(size_before);
        for (int i = RD_LAT - 1; i > 0; i--) q_pipe[i] = q_pipe[i-1];
        q_pipe[0] = did_pop ? popped : junk();
        fifo_q    = q_pipe[RD_LAT-1];
        rst       = rst_next;
        out_ready = random_ready ? 1'($urandom_range(0, 1)) : ready_next;
`ifdef FIFO144_RD_UNPACK_STATS_EN
        stats_clr = clr_next;
`endif
        if (wr_remaining > 0 && mem.size() < 32 && $urandom_range(0, 1) == 1) begin
            mem.push_back(mk_entry(wr_idx));
            wr_idx++;
            wr_remaining--;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_rd, base_beats, guard;
        logic [143:0] e0;

        vecs[0] = '{144'h123456789ABCDEF00F_EDCBA987654321ABCD, 72'hEDCBA987654321ABCD, 72'h123456789ABCDEF00F};
        vecs[1] = '{144'h000000000000000000_FFFFFFFFFFFFFFFFFF, 72'hFFFFFFFFFFFFFFFFFF, 72'h000000000000000000};
        vecs[2] = '{144'hFFFFFFFFFFFFFFFFFF_000000000000000000, 72'h000000000000000000, 72'hFFFFFFFFFFFFFFFFFF};
        vecs[3] = '{144'hA5A5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A5A, 72'h5A5A5A5A5A5A5A5A5A, 72'hA5A5A5A5A5A5A5A5A5};

        n_checks = 0; n_fail = 0; cycle = 0; rdreq_total = 0; beats = 0;
        stall_seen = 0; underflow = 0; outstanding = 0; last_rdreq_cyc = 0;
        wr_remaining = 0; wr_idx = 0;
        stall_prev = 1'b0; prev_hi = 1'b0; prev_data = '0;
        rst = 1'b1; rst_next = 1'b1;
        out_ready = 1'b0; ready_next = 1'b0; random_ready = 1'b0; clr_next = 1'b0;
        fifo_q = '0; fifo_usedw = 6'd5;
        for (int i = 0; i < RD_LAT; i++) q_pipe[i] = '0;
`ifdef FIFO144_RD_UNPACK_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int i = 0; i < 5; i++) mem.push_back(mk_entry(900 + i));

        // Reset held with a non-empty FIFO: nothing may be read.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus();
        mem.delete();
        rst_next = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("post_rst_valid", out_valid, 0);
        checkOutput("post_rst_rdreq_total", rdreq_total, 0);
`ifdef FIFO144_RD_UNPACK_STATS_EN
        checkOutput("post_rst_rd_cnt", rd_cnt, 0);
`endif

        // Single-entry vectors.
        ready_next = 1'b1;
        applyStimulus();
        for (int v = 0; v < 4; v++) begin
            beat_log.delete();
            base_rd = rdreq_total;
            mem.push_back(vecs[v].q);
            guard = 0;
            while (beat_log.size() < 2 && guard < 30) begin
                applyStimulus();
                guard++;
            end
            for (int i = 0; i < 3; i++) applyStimulus();
            checkOutput("vec_rdreq_pulses", rdreq_total - base_rd, 1);
            checkOutput("vec_beat_count", beat_log.size(), 2);
            if (beat_log.size() >= 2) begin
                checkOutput("vec_beat0_hi", beat_log[0].hi, 0);
                checkOutput("vec_beat0_data", beat_log[0].data, vecs[v].exp_lo);
                checkOutput("vec_beat1_hi", beat_log[1].hi, 1);
                checkOutput("vec_beat1_data", beat_log[1].data, vecs[v].exp_hi);
                checkOutput("vec_latency", beat_log[0].cyc - last_rdreq_cyc, RD_LAT + 1);
            end
            checkOutput("vec_idle_valid", out_valid, 0);
            checkOutput("vec_idle_busy", busy, 0);
        end

        // Backpressure: 20 entries, downstream stalled for 50 valid cycles.
        clr_next = 1'b1;
        applyStimulus();
        clr_next = 1'b0;
        applyStimulus();
        base_rd    = rdreq_total;
        base_beats = beats;
        for (int i = 0; i < 20; i++) mem.push_back(mk_entry(100 + i));
        e0 = mk_entry(100);
        out_ready  = 1'b0;
        ready_next = 1'b0;
        stall_seen = 0;
        guard = 0;
        while (stall_seen < 50 && guard < 200) begin
            applyStimulus();
            guard++;
        end
        checkOutput("bp_stall_cycles", stall_seen, 50);
        checkOutput("bp_rdreq_pulses", rdreq_total - base_rd, BUF_DEPTH);
        checkOutput("bp_hold_valid", out_valid, 1);
        checkOutput("bp_hold_hi", out_hi, 0);
        checkOutput("bp_hold_data", out_data, e0[71:0]);
`ifdef FIFO144_RD_UNPACK_STATS_EN
        checkOutput("bp_stall_cnt", stall_cnt, 50);
        checkOutput("bp_rd_cnt", rd_cnt, BUF_DEPTH);
`endif
        out_ready  = 1'b1;
        ready_next = 1'b1;
        guard = 0;
        while ((beats - base_beats) < 40 && guard < 300) begin
            applyStimulus();
            guard++;
        end
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("bp_beats", beats - base_beats, 40);
        checkOutput("bp_sb_empty", exp_q.size(), 0);

        // Streaming: full FIFO, always ready.
        beat_log.delete();
        for (int i = 0; i < 32; i++) mem.push_back(mk_entry(200 + i));
        guard = 0;
        while (beat_log.size() < 64 && guard < 400) begin
            applyStimulus();
            guard++;
        end
        checkOutput("stream_beats", beat_log.size(), 64);
        if (beat_log.size() >= 64)
            checkOutput("stream_continuous", beat_log[63].cyc - beat_log[0].cyc, 63);
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("stream_underflow", underflow, 0);
        checkOutput("stream_busy_end", busy, 0);

        // Random ready with random FIFO writes.
        base_beats   = beats;
        random_ready = 1'b1;
        wr_remaining = 1000;
        guard = 0;
        while ((beats - base_beats) < 2000 && guard < 20000) begin
            applyStimulus();
            guard++;
        end
        random_ready = 1'b0;
        ready_next   = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("rand_beats", beats - base_beats, 2000);
        checkOutput("rand_sb_empty", exp_q.size(), 0);
        checkOutput("rand_underflow", underflow, 0);
        checkOutput("rand_busy_end", busy, 0);

        // Reset with two reads in flight and one entry buffered.
        out_ready  = 1'b0;
        ready_next = 1'b0;
        for (int i = 0; i < 3; i++) mem.push_back(mk_entry(300 + i));
        base_rd = rdreq_total;
        guard = 0;
        while (rdreq_total == base_rd && guard < 20) begin
            applyStimulus();
            guard++;
        end
        checkOutput("mid_rst_first_rdreq", rdreq_total - base_rd, 1);
        applyStimulus();
        checkOutput("mid_rst_busy_before", busy, 1);
        rst_next = 1'b1;
        applyStimulus();
        rst_next = 1'b0;
        applyStimulus();
`ifdef FIFO144_RD_UNPACK_STATS_EN
        checkOutput("mid_rst_rd_cnt", rd_cnt, 0);
        checkOutput("mid_rst_stall_cnt", stall_cnt, 0);
`endif
        out_ready  = 1'b1;
        ready_next = 1'b1;
        base_beats = beats;
        for (int i = 0; i < 20; i++) applyStimulus();
        checkOutput("mid_rst_no_beats", beats - base_beats, 0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
